// File: rtl/crypto_sched.sv
// Round-robin scheduler sharing one crypto engine among NUM_REQ requesters, with a lockable key table.
// Optional build macro CRYPTO_SCHED_TIMEOUT_EN adds a WAIT-state timeout that returns an error response.
module crypto_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_KEYS    = 4,
  parameter int unsigned KIDX_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*128-1:0]      req_data,
  input  logic [NUM_REQ*KIDX_W-1:0]   req_key_idx,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [127:0]                rsp_data,
  output logic                        rsp_err,
  input  logic                        cfg_we,
  input  logic [KIDX_W-1:0]           cfg_addr,
  input  logic [127:0]                cfg_key,
  input  logic                        cfg_lock,
  output logic                        eng_start,
  output logic [127:0]                eng_key,
  output logic [127:0]                eng_data_in,
  input  logic [127:0]                eng_data_out,
  input  logic                        eng_done,
  output logic                        busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [KIDX_W-1:0]   r_kidx;
  logic [127:0]        r_data;
  logic [127:0]        r_eng_key;
  logic [127:0]        r_rsp_data;
  logic                r_rsp_err;
  logic                r_lock;
  logic [127:0]        r_keys [NUM_KEYS];

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0]    r_tmo;
`endif

  logic                w_hit;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [127:0]        w_gnt_data;
  logic [KIDX_W-1:0]   w_gnt_kidx;
  logic [NUM_REQ-1:0]  w_one;
  logic [PTR_W-1:0]    w_ptr_next;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned v_j;
    w_hit     = 1'b0;
    w_gnt_idx = '0;
    v_j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_j = 32'(r_rr_ptr) + k;
      if (v_j >= NUM_REQ) v_j = v_j - NUM_REQ;
      if (!w_hit && req_valid[PTR_W'(v_j)]) begin
        w_hit     = 1'b1;
        w_gnt_idx = PTR_W'(v_j);
      end
    end
  end

  assign w_one      = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign w_gnt_data = req_data[128*w_gnt_idx +: 128];
  assign w_gnt_kidx = req_key_idx[KIDX_W*w_gnt_idx +: KIDX_W];
  assign w_ptr_next = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

  assign req_ready   = (r_state == S_IDLE && w_hit) ? (w_one << w_gnt_idx) : '0;
  assign rsp_valid   = (r_state == S_RESP) ? (w_one << r_owner) : '0;
  assign rsp_data    = r_rsp_data;
  assign eng_start   = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign eng_data_in = r_data;
  // During ISSUE the key is read straight from the table, so a same-cycle write is not yet visible
  assign eng_key     = (r_state == S_ISSUE) ? r_keys[r_kidx] : r_eng_key;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_kidx     <= '0;
      r_data     <= '0;
      r_eng_key  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_lock     <= 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) r_keys[KIDX_W'(i)] <= '0;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      r_lock <= r_lock | cfg_lock;
      if (cfg_we && !r_lock) r_keys[cfg_addr] <= cfg_key;

      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_owner <= w_gnt_idx;
            r_data  <= w_gnt_data;
            r_kidx  <= w_gnt_kidx;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_eng_key <= r_keys[r_kidx];
          r_state   <= S_WAIT;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
          r_tmo     <= '0;
`endif
        end
        S_WAIT: begin
          if (eng_done) begin
            r_rsp_data <= eng_data_out;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end
`ifdef CRYPTO_SCHED_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYC-1)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready[r_owner]) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= w_ptr_next;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_data     <= '0;
            r_eng_key  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_sched.sv
// Randomized self-checking bench for crypto_sched with a behavioural engine and scheduler model.
module tb_crypto_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned NK  = 4;
  localparam int unsigned TMO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*128-1:0] req_data;
  logic [NR*2-1:0]   req_key_idx;
  logic [127:0]      rsp_data, cfg_key, eng_key, eng_data_in, eng_data_out;
  logic              rsp_err, cfg_we, cfg_lock, eng_start, eng_done, busy;
  logic [1:0]        cfg_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] m_keys [NK];
  bit           m_lock;
  int           m_ptr;

  bit           eng_mute  = 1'b0;
  bit           stray_req = 1'b0;
  int           e_cnt     = 0;
  logic [127:0] e_res;

  crypto_sched #(.NUM_REQ(NR), .NUM_KEYS(NK), .KIDX_W(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key_idx(req_key_idx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_lock(cfg_lock),
    .eng_start(eng_start), .eng_key(eng_key), .eng_data_in(eng_data_in),
    .eng_data_out(eng_data_out), .eng_done(eng_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in engine: result = data + key + 1, done two cycles after start
  always @(negedge clk) begin
    if (reset) begin
      e_cnt    = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done     = 1'b1;
          eng_data_out = e_res;
        end
      end
      if (eng_start && !eng_mute) begin
        e_res = eng_data_in + eng_key + 128'd1;
        e_cnt = 2;
      end
      if (stray_req) begin
        eng_done     = 1'b1;
        eng_data_out = {$urandom, $urandom, $urandom, $urandom};
        stray_req    = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_grant(input logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NK; i++) m_keys[i] = '0;
    m_lock = 1'b0;
    m_ptr  = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; cfg_we = 1'b0; cfg_lock = 1'b0;
    cfg_addr = '0; cfg_key = '0; req_data = '0; req_key_idx = '0;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [127:0] k, input bit we, input bit lk);
    cfg_we = we; cfg_addr = a; cfg_key = k; cfg_lock = lk;
    if (we && !m_lock) m_keys[a] = k;
    m_lock = m_lock | lk;
    @(negedge clk);
    cfg_we = 1'b0; cfg_lock = 1'b0;
  endtask

  // One full transaction, started at a negedge with the scheduler idle
  task automatic run_txn(input logic [NR-1:0] mask, input int hold, input int fidx,
                         input bit use_fd, input logic [127:0] fd,
                         input bit iwr, input logic [1:0] iaddr, input logic [127:0] ikey,
                         input bit mute);
    logic [127:0] d [NR];
    logic [1:0]   kx [NR];
    logic [127:0] exp_key, exp_rsp, held;
    logic [NR-1:0] own;
    int g, n, exp_lat;
    for (int i = 0; i < NR; i++) begin
      d[i]  = {$urandom, $urandom, $urandom, $urandom};
      kx[i] = 2'($urandom_range(0, 3));
      if (fidx >= 0) kx[i] = 2'(fidx);
      if (use_fd) d[i] = fd;
      req_data[128*i +: 128] = d[i];
      req_key_idx[2*i +: 2]  = kx[i];
    end
    g   = m_grant(mask);
    own = 4'(1 << g);
    eng_mute  = mute;
    req_valid = mask;
    rsp_ready = '0;
    #1;
    check("grant", req_ready, own);
    check("busy_idle", busy, 0);
    exp_key = m_keys[kx[g]];
    exp_rsp = d[g] + exp_key + 128'd1;
    @(negedge clk);
    req_valid = '0;
    if (iwr) begin
      cfg_we = 1'b1; cfg_addr = iaddr; cfg_key = ikey;
      if (!m_lock) m_keys[iaddr] = ikey;
    end
    #1;
    check("issue_start", eng_start, 1);
    check("issue_key", eng_key, exp_key);
    check("issue_data", eng_data_in, d[g]);
    check("issue_ready", req_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    check("wait_start", eng_start, 0);
    check("wait_key", eng_key, exp_key);
    n = 1;
    while (rsp_valid == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    exp_lat = mute ? TMO + 1 : 3;
    check("latency", 128'(n), 128'(exp_lat));
    check("rsp_valid", rsp_valid, own);
    check("rsp_data", rsp_data, mute ? 128'd0 : exp_rsp);
    check("rsp_err", rsp_err, mute);
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 4'($urandom) & ~own;
      req_valid = 4'($urandom);
      @(negedge clk);
      check("hold_valid", rsp_valid, own);
      check("hold_data", rsp_data, held);
      check("hold_nogrant", req_ready, 0);
    end
    req_valid = '0;
    rsp_ready = 4'($urandom) | own;
    @(negedge clk);
    rsp_ready = '0;
    eng_mute  = 1'b0;
    m_ptr = (g + 1) % NR;
    check("done_valid", rsp_valid, 0);
    check("done_data", rsp_data, 0);
    check("done_din", eng_data_in, 0);
    check("done_busy", busy, 0);
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    do_reset();

    // round-robin under full contention
    cfg_write(2'd0, 128'h0F, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      check("rr_ptr_model", 128'(m_grant(4'b1111)), 128'(seq[t]));
      run_txn(4'b1111, 0, -1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    end

    // basic transaction with known key and data
    run_txn(4'b0001, 0, 0, 1'b1, 128'hF0, 1'b0, '0, '0, 1'b0);
    check("t1_key0", m_keys[0] + 128'hF0 + 128'd1, 128'h100);

    // response back-pressure
    run_txn(4'b0100, 10, -1, 1'b0, '0, 1'b0, '0, '0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), -1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    end

    // key write colliding with ISSUE of the same index
    cfg_write(2'd1, 128'h1111, 1'b1, 1'b0);
    run_txn(4'b0010, 0, 1, 1'b0, '0, 1'b1, 2'd1, 128'h2222, 1'b0);
    run_txn(4'b0010, 0, 1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    check("t5_newkey", m_keys[1], 128'h2222);

    // engine done outside WAIT
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_valid", rsp_valid, 0);
    check("stray_data", rsp_data, 0);

    // lock then attempted overwrite
    cfg_write(2'd0, 128'h0F, 1'b1, 1'b0);
    cfg_write(2'd0, '0, 1'b0, 1'b1);
    cfg_write(2'd0, 128'hAA, 1'b1, 1'b0);
    run_txn(4'b1000, 0, 0, 1'b1, 128'h1000, 1'b0, '0, '0, 1'b0);
    run_txn(4'b0001, 0, 0, 1'b1, 128'hF0, 1'b0, '0, '0, 1'b0);

`ifdef CRYPTO_SCHED_TIMEOUT_EN
    run_txn(4'b0010, 2, -1, 1'b0, '0, 1'b0, '0, '0, 1'b1);
`endif

    // reset while waiting on the engine
    eng_mute = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("wait_busy", busy, 1);
    check("wait_novalid", rsp_valid, 0);
    eng_mute = 1'b0;
    do_reset();

    // keys cleared and lock released by reset
    run_txn(4'b0001, 0, 0, 1'b1, 128'h55, 1'b0, '0, '0, 1'b0);
    cfg_write(2'd0, 128'hAA, 1'b1, 1'b0);
    run_txn(4'b0011, 0, 0, 1'b1, 128'h10, 1'b0, '0, '0, 1'b0);
    check("t4_unlocked", m_keys[0], 128'hAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
